// File: rtl/acc_sched_pkg.sv
// Shared types and helpers for the accumulator scheduler: FSM state encoding
// and the requester-index width helper.
package acc_sched_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_CLEAR = S_CLEAR,
        ST_RUN   = S_RUN,
        ST_DONE  = S_DONE
    } state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_sched_if.sv
// Requester/host-facing bus of the accumulator scheduler, plus the
// accumulator control outputs and status it produces.
interface acc_sched_if
    import acc_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADD_WIDTH  = 1,
    parameter int BEAT_WIDTH = 8
);
    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADD_WIDTH-1:0]  req_value;
    logic [NUM_REQ*BEAT_WIDTH-1:0] req_beats;
    logic                          clr_req;
    logic [ADD_WIDTH-1:0]          acc_add_value;
    logic                          acc_clr;
    logic                          busy;
    logic                          done;
    logic [ID_W-1:0]               done_id;

    modport master (
        output req_valid, req_value, req_beats, clr_req,
        input  req_ready, acc_add_value, acc_clr, busy, done, done_id
    );

    modport slave (
        input  req_valid, req_value, req_beats, clr_req,
        output req_ready, acc_add_value, acc_clr, busy, done, done_id
    );
endinterface

// File: rtl/acc_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the priority
// pointer, which advances past the granted index only when update is high.
module rr_arbiter
    import acc_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);
    logic [ID_W-1:0] ptr_reg;
    logic            found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req[(int'(ptr_reg) + k) % NUM_REQ]) begin
                    found     = 1'b1;
                    grant_idx = ID_W'((int'(ptr_reg) + k) % NUM_REQ);
                end
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (update) begin
            ptr_reg <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/acc_sched.sv
// Shares one accumulator between NUM_REQ requesters: round-robin accept, then
// add the latched operand for the requested number of beats, then pulse done.
module acc_sched
    import acc_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADD_WIDTH  = 1,
    parameter int BEAT_WIDTH = 8,
    localparam int ID_W      = id_w(NUM_REQ)
) (
    input logic        clk,
    input logic        rst,
    acc_sched_if.slave bus
);
    state_t                state_reg;
    logic [ADD_WIDTH-1:0]  value_reg;
    logic [BEAT_WIDTH-1:0] cnt_reg;
    logic [ID_W-1:0]       id_reg;
    logic [ADD_WIDTH-1:0]  add_value_reg;
    logic                  acc_clr_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [ID_W-1:0]       done_id_reg;

    logic [ADD_WIDTH-1:0]  value_arr [NUM_REQ];
    logic [BEAT_WIDTH-1:0] beats_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  arb_en;
    logic                  accept;
    logic [ADD_WIDTH-1:0]  sel_value;
    logic [BEAT_WIDTH-1:0] sel_beats;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign value_arr[gi] = bus.req_value[gi*ADD_WIDTH +: ADD_WIDTH];
            assign beats_arr[gi] = bus.req_beats[gi*BEAT_WIDTH +: BEAT_WIDTH];
        end
    endgenerate

    // A pending clear blocks the arbiter so it always wins over requesters.
    assign arb_en    = (state_reg == ST_IDLE) && !bus.clr_req;
    assign accept    = |grant;
    assign sel_value = value_arr[grant_idx];
    assign sel_beats = beats_arr[grant_idx];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .en        (arb_en),
        .update    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            value_reg     <= '0;
            cnt_reg       <= '0;
            id_reg        <= '0;
            add_value_reg <= '0;
            acc_clr_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            done_id_reg   <= '0;
        end else begin
            add_value_reg <= '0;
            acc_clr_reg   <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state_reg   <= ST_CLEAR;
                        acc_clr_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                    end else if (accept) begin
                        value_reg <= sel_value;
                        cnt_reg   <= sel_beats;
                        id_reg    <= grant_idx;
                        busy_reg  <= 1'b1;
                        if (sel_beats != '0) begin
                            state_reg     <= ST_RUN;
                            add_value_reg <= sel_value;
                        end else begin
                            state_reg   <= ST_DONE;
                            done_reg    <= 1'b1;
                            done_id_reg <= grant_idx;
                        end
                    end
                end
                ST_CLEAR: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                ST_RUN: begin
                    // cnt_reg counts the remaining add cycles including this one.
                    if (cnt_reg == BEAT_WIDTH'(1)) begin
                        state_reg   <= ST_DONE;
                        done_reg    <= 1'b1;
                        done_id_reg <= id_reg;
                    end else begin
                        cnt_reg       <= cnt_reg - 1'b1;
                        add_value_reg <= value_reg;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready     = grant;
    assign bus.acc_add_value = add_value_reg;
    assign bus.acc_clr       = acc_clr_reg;
    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.done_id       = done_id_reg;
endmodule

// File: tb/tb_acc_sched.sv
// Scoreboard bench for acc_sched: directed scenarios push expected events and
// per-cycle add/busy windows; a negedge monitor compares what the DUT presents.
module tb_acc_sched;
    localparam int NR = 4;
    localparam int AW = 4;
    localparam int BW = 4;

    typedef struct {
        int kind;   // 0 ready, 1 done, 2 clear
        int idx;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] acc = 8'd0;

    ev_t exp_q[$];
    int  exp_add[int];
    bit  exp_busy[int];
    string kname[3] = '{"ready", "done", "clear"};

    acc_sched_if #(.NUM_REQ(NR), .ADD_WIDTH(AW), .BEAT_WIDTH(BW)) bus ();

    acc_sched #(.NUM_REQ(NR), .ADD_WIDTH(AW), .BEAT_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator model driven by the scheduler outputs.
    always @(posedge clk) begin
        if (mon_en) begin
            if (bus.acc_clr) acc <= 8'd0;
            else             acc <= acc + {4'd0, bus.acc_add_value};
        end
    end

    task automatic check_val(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic observe(input int kind, input int idx);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got %s idx=%0d at cycle %0d, expected no event",
                     kname[kind], idx, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.idx != idx || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL event: got %s idx=%0d at cycle %0d, expected %s idx=%0d at cycle %0d",
                         kname[kind], idx, cyc, kname[e.kind], e.idx, e.cyc);
            end else begin
                $display("ok   %s idx=%0d at cycle %0d", kname[kind], idx, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            int ea;
            bit eb;
            ea = exp_add.exists(cyc) ? exp_add[cyc] : 0;
            eb = exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0;
            if (int'(bus.acc_add_value) != ea) begin
                n_checks++;
                n_fail++;
                $display("FAIL acc_add_value: got %0d, expected %0d (cycle %0d)",
                         bus.acc_add_value, ea, cyc);
            end
            if (bus.busy !== eb) begin
                n_checks++;
                n_fail++;
                $display("FAIL busy: got %0b, expected %0b (cycle %0d)", bus.busy, eb, cyc);
            end
            if ($countones(bus.req_ready) > 1) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_ready one-hot: got %b (cycle %0d)", bus.req_ready, cyc);
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ready[i]) observe(0, i);
            end
            if (bus.done)    observe(1, int'(bus.done_id));
            if (bus.acc_clr) observe(2, 0);
        end
    end

    task automatic push_ev(input int kind, input int idx, input int c);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_req(input int i, input int v, input int b, input int t);
        push_ev(0, i, t);
        for (int c = t + 1; c <= t + b; c++) exp_add[c] = v;
        for (int c = t + 1; c <= t + b + 1; c++) exp_busy[c] = 1'b1;
        push_ev(1, i, t + b + 1);
    endtask

    task automatic set_req(input int i, input int v, input int b);
        bus.req_valid[i]         = 1'b1;
        bus.req_value[i*AW +: AW] = AW'(v);
        bus.req_beats[i*BW +: BW] = BW'(b);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t;
        int acc0;
        bus.req_valid = '0;
        bus.req_value = '0;
        bus.req_beats = '0;
        bus.clr_req   = 1'b0;

        tick(3);
        check_val("reset req_ready", int'(bus.req_ready), 0);
        check_val("reset acc_add_value", int'(bus.acc_add_value), 0);
        check_val("reset acc_clr", int'(bus.acc_clr), 0);
        check_val("reset busy", int'(bus.busy), 0);
        check_val("reset done", int'(bus.done), 0);
        check_val("reset done_id", int'(bus.done_id), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(1);

        // All four valid, beats 1: grants 0,1,2,3,0 three cycles apart.
        t = cyc; acc0 = int'(acc);
        for (int i = 0; i < NR; i++) set_req(i, i + 1, 1);
        for (int k = 0; k < 5; k++) push_req(k % NR, (k % NR) + 1, 1, t + 3*k);
        tick(13);
        bus.req_valid = '0;
        tick(3);
        check_val("round robin acc gain", int'(acc) - acc0, 11);

        // Single request: requester 2, value 3, beats 5.
        t = cyc; acc0 = int'(acc);
        set_req(2, 3, 5);
        push_req(2, 3, 5, t);
        tick(1);
        bus.req_valid = '0;
        tick(6);
        check_val("single request acc gain", int'(acc) - acc0, 15);

        // Zero beats: done the next cycle, no add.
        t = cyc; acc0 = int'(acc);
        set_req(1, 7, 0);
        push_req(1, 7, 0, t);
        tick(1);
        bus.req_valid = '0;
        tick(2);
        check_val("zero beats acc gain", int'(acc) - acc0, 0);

        // Clear beats a simultaneous request; the request follows two cycles later.
        t = cyc;
        bus.clr_req = 1'b1;
        set_req(0, 5, 1);
        push_ev(2, 0, t + 1);
        exp_busy[t + 1] = 1'b1;
        push_req(0, 5, 1, t + 2);
        tick(1);
        bus.clr_req = 1'b0;
        tick(2);
        bus.req_valid = '0;
        tick(3);
        check_val("clear then add acc", int'(acc), 5);

        // Reset during the third RUN cycle of a beats-8 request.
        t = cyc; acc0 = int'(acc);
        set_req(2, 2, 8);
        push_ev(0, 2, t);
        for (int c = t + 1; c <= t + 3; c++) begin
            exp_add[c]  = 2;
            exp_busy[c] = 1'b1;
        end
        tick(1);
        bus.req_valid = '0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_val("post-reset busy", int'(bus.busy), 0);
        check_val("mid-run reset acc gain", int'(acc) - acc0, 6);

        // Pointer back at 0: requester 1 wins over 3; 3 withdraws during RUN.
        t = cyc; acc0 = int'(acc);
        set_req(1, 1, 4);
        set_req(3, 9, 3);
        push_req(1, 1, 4, t);
        tick(1);
        bus.req_valid[1] = 1'b0;
        tick(2);
        bus.req_valid[3] = 1'b0;
        tick(6);
        check_val("withdrawn scenario acc gain", int'(acc) - acc0, 4);

        check_val("pending expected events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/acc_sched.md
# acc_sched

Round-robin scheduler that shares one accumulator datapath (an `accumulator_rca`-style adder/register) between `NUM_REQ` requesters. Each granted request adds a fixed `value` into the accumulator for `beats` consecutive cycles. The block also sequences a synchronous accumulator clear and reports completion. It sits between the requester logic and the accumulator instance, and owns that instance's `add_value` and clear inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADD_WIDTH`, default 1: width of the add operand, matching the accumulator's `ADD_WIDTH`.
- `BEAT_WIDTH`, default 8: width of the per-request beat count.
- `clk` input 1: the single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NUM_REQ: request pending, one bit per requester.
- `req_ready` output NUM_REQ: one-hot accept strobe.
- `req_value` input NUM_REQ*ADD_WIDTH: operand. Requester i occupies bits [i*ADD_WIDTH +: ADD_WIDTH].
- `req_beats` input NUM_REQ*BEAT_WIDTH: number of add cycles, packed the same way.
- `clr_req` input 1: host request to zero the accumulator.
- `acc_add_value` output ADD_WIDTH: drives the accumulator's `add_value`.
- `acc_clr` output 1: one-cycle synchronous clear to the accumulator.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse when a request completes.
- `done_id` output $clog2(NUM_REQ): requester index, valid while `done` is high.

## Operation
- States: IDLE, CLEAR, RUN, DONE. Encoding is held in the package.
- **IDLE**
  - `clr_req` has priority over all requesters. If `clr_req` is high: no `req_ready`, next state CLEAR.
  - Otherwise, if any `req_valid` is high, the arbiter grants exactly one index g, and `req_ready[g]` is high combinationally in the same cycle.
  - On accept (valid & ready), the block latches `value_r`, `beats_r` and `id_r = g`.
    - If `beats_r` is nonzero: next state RUN.
    - If `beats_r` is 0: next state DONE. No add cycles occur.
- **CLEAR**: `acc_clr` = 1 for exactly one cycle, then IDLE. No `done` pulse.
- **RUN**
  - `acc_add_value` = `value_r`.
  - A down-counter starts at `beats_r` and decrements each cycle.
  - When the counter reaches 1, next state is DONE.
- **DONE**: `done` = 1 and `done_id` = `id_r` for one cycle, then IDLE.
- `acc_add_value` = 0 in every state except RUN, so the accumulator holds its value.
- Round-robin rule:
  - After a grant to g, priority starts at (g+1) mod NUM_REQ.
  - After reset, the pointer is 0 (requester 0 has highest priority).
  - The pointer updates only on accept. A clear does not move it.
- Requesters hold `req_valid`, `req_value` and `req_beats` stable until they see `req_ready`. Dropping valid before ready is legal: the request is withdrawn and is not serviced.
- `req_valid` changes during RUN have no effect on the current request.
- `clr_req` arriving during RUN or DONE is not lost as long as it is held. It is serviced on the next IDLE cycle, ahead of all requesters.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - state IDLE and round-robin pointer 0;
  - `req_ready` = 0, `acc_add_value` = 0, `acc_clr` = 0;
  - `busy` = 0, `done` = 0, `done_id` = 0.
- Accept in cycle T with `beats` = B > 0:
  - RUN during cycles T+1 .. T+B, with `acc_add_value` = value;
  - `done` in cycle T+B+1;
  - earliest next accept in T+B+2.
- Accept in cycle T with B = 0: `done` in cycle T+1, earliest next accept in T+2.
- Clear accepted in cycle T: `acc_clr` in cycle T+1, earliest next accept in T+2.
- The accumulator sees the add in the same cycles as RUN, so it gains value × B in total (modulo 2^ACC_WIDTH; wrap-around is the accumulator's job).
- `rst` during RUN: the next cycle is IDLE with outputs at their reset values, and no `done` pulse. The accumulator is not cleared by this block; its own reset is separate.
- Maximum B = 2^BEAT_WIDTH − 1. No overflow handling is required because the counter only decrements.

## Structure
- Package `acc_sched_pkg` holds:
  - the state enum;
  - the `ID_W = $clog2(NUM_REQ)` helper;
  - localparams for the state encodings.
- Sub-module `rr_arbiter` (parameter NUM_REQ):
  - inputs: request vector, enable, update;
  - outputs: one-hot grant and grant index;
  - contains the round-robin pointer register.
- The top-level `acc_sched` holds the FSM, the operand/beat/id registers and the beat counter.

## Test plan
All scenarios use NUM_REQ=4, ADD_WIDTH=4, BEAT_WIDTH=4, with an accumulator model attached.
- Single request: `req_valid[2]` with value 3, beats 5 → `req_ready[2]` in cycle T; `acc_add_value` = 3 during T+1..T+5; `done` with `done_id` = 2 at T+6; accumulator +15.
- All four valid continuously, each with beats 1 → grant order 0,1,2,3,0; each `done` 3 cycles apart.
- Zero beats: requester 1 with beats 0 → `done` at T+1; `acc_add_value` stays 0; accumulator unchanged.
- Clear priority: `clr_req` and `req_valid[0]` both high in IDLE → `acc_clr` in the next cycle; requester 0 accepted 2 cycles after the clear was accepted; round-robin pointer unchanged.
- Reset mid-RUN: `rst` in the 3rd RUN cycle of a beats-8 request → IDLE next cycle; no `done`; pointer 0.
- Withdrawn request: requester 3 drops `req_valid` while requester 1 is in RUN → requester 3 is never granted; no spurious `req_ready`.
